// File: rtl/nco_voice_scheduler.sv
// nco_voice_scheduler: note-event voice allocator that sequences the shared NCO datapath through every slot per sample tick.
module nco_voice_scheduler #(
   parameter int VOICES = 4,
   parameter int VIDX_W = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              SAMPLE_TICK,
   input  logic              EV_VALID,
   output logic              EV_READY,
   input  logic              EV_NOTE_ON,
   input  logic [6:0]        EV_NOTE,
   input  logic [6:0]        EV_VEL,
   output logic              VOICE_STB,
   output logic [VIDX_W-1:0] VOICE_IDX,
   output logic [6:0]        VOICE_NOTE,
   output logic [6:0]        VOICE_VEL,
   output logic              VOICE_GATE,
   output logic              VOICE_RESTART,
   output logic              FRAME_DONE,
   output logic              OVERRUN,
   output logic [VIDX_W:0]   ACTIVE_CNT
);
   typedef enum logic [2:0] {IDLE, EVAL, WRITE, SCAN, DONE} state_t;
   state_t state_q, state_d;
   logic [VOICES-1:0] gate_q, rs_q;
   logic [6:0] note_q [VOICES];
   logic [6:0] vel_q [VOICES];
   logic [VIDX_W-1:0] steal_q, scan_q, match_q, free_q, m_idx, f_idx, wr_idx, sidx;
   logic hit_q, has_free_q, m_hit, f_hit, pend_q, ev_on_q, go, last, load, accept;
   logic [6:0] ev_note_q, ev_vel_q;
   logic [VIDX_W:0] pop;
   assign go = pend_q | SAMPLE_TICK;
   assign last = scan_q == VIDX_W'(VOICES - 1);
   always_ff @(posedge CLK) begin
      if (RST) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = go ? SCAN : (EV_VALID ? EVAL : IDLE);
         EVAL:    state_d = WRITE;
         WRITE:   state_d = IDLE;
         SCAN:    state_d = last ? DONE : SCAN;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      EV_READY = (state_q == IDLE) && !go;
      accept   = EV_READY && EV_VALID;
      load     = ((state_q == IDLE) && go) || ((state_q == SCAN) && !last);
      sidx     = (state_q == IDLE) ? '0 : scan_q + 1'b1;
      wr_idx   = hit_q ? match_q : (has_free_q ? free_q : steal_q);
   end
   // Descending search so the lowest qualifying slot wins.
   always_comb begin
      m_hit = 1'b0;
      m_idx = '0;
      f_hit = 1'b0;
      f_idx = '0;
      pop   = '0;
      for (int i = VOICES - 1; i >= 0; i--) begin
         if (gate_q[i] && note_q[i] == ev_note_q) begin
            m_hit = 1'b1;
            m_idx = VIDX_W'(i);
         end
         if (!gate_q[i]) begin
            f_hit = 1'b1;
            f_idx = VIDX_W'(i);
         end
         pop = pop + (VIDX_W + 1)'(gate_q[i]);
      end
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         gate_q <= '0;
         rs_q <= '0;
         for (int i = 0; i < VOICES; i++) begin
            note_q[i] <= '0;
            vel_q[i] <= '0;
         end
         steal_q <= '0;
         scan_q <= '0;
         match_q <= '0;
         free_q <= '0;
         hit_q <= 1'b0;
         has_free_q <= 1'b0;
         pend_q <= 1'b0;
         ev_on_q <= 1'b0;
         ev_note_q <= '0;
         ev_vel_q <= '0;
         VOICE_STB <= 1'b0;
         VOICE_IDX <= '0;
         VOICE_NOTE <= '0;
         VOICE_VEL <= '0;
         VOICE_GATE <= 1'b0;
         VOICE_RESTART <= 1'b0;
         FRAME_DONE <= 1'b0;
         OVERRUN <= 1'b0;
         ACTIVE_CNT <= '0;
      end else begin
         if (accept) begin
            ev_on_q <= EV_NOTE_ON && (EV_VEL != 7'd0);
            ev_note_q <= EV_NOTE;
            ev_vel_q <= EV_VEL;
         end
         if (state_q == EVAL) begin
            hit_q <= m_hit;
            match_q <= m_idx;
            has_free_q <= f_hit;
            free_q <= f_idx;
         end
         if (state_q == WRITE) begin
            if (ev_on_q) begin
               gate_q[wr_idx] <= 1'b1;
               note_q[wr_idx] <= ev_note_q;
               vel_q[wr_idx] <= ev_vel_q;
               rs_q[wr_idx] <= 1'b1;
               if (!hit_q && !has_free_q) steal_q <= (steal_q == VIDX_W'(VOICES - 1)) ? '0 : steal_q + 1'b1;
            end else if (hit_q) gate_q[match_q] <= 1'b0;
         end
         if (load) begin
            scan_q <= sidx;
            rs_q[sidx] <= 1'b0;
         end
         VOICE_STB <= load;
         VOICE_IDX <= load ? sidx : '0;
         VOICE_NOTE <= load ? note_q[sidx] : '0;
         VOICE_VEL <= load ? vel_q[sidx] : '0;
         VOICE_GATE <= load && gate_q[sidx];
         VOICE_RESTART <= load && rs_q[sidx];
         FRAME_DONE <= (state_q == SCAN) && last;
         pend_q <= ((state_q == IDLE) && go) ? 1'b0 : (pend_q | (SAMPLE_TICK && state_q != IDLE));
         OVERRUN <= OVERRUN | (SAMPLE_TICK && (state_q == SCAN || state_q == DONE));
         ACTIVE_CNT <= pop;
      end
   end
endmodule

// File: tb/tb_nco_voice_scheduler.sv
// tb_nco_voice_scheduler: directed vectors with hand-computed expectations for the voice scheduler.
module tb_nco_voice_scheduler;
   localparam int V = 4;
   logic CLK = 1'b0, RST = 1'b1, SAMPLE_TICK = 1'b0, EV_VALID = 1'b0, EV_NOTE_ON = 1'b0;
   logic [6:0] EV_NOTE = '0, EV_VEL = '0;
   logic EV_READY, VOICE_STB, VOICE_GATE, VOICE_RESTART, FRAME_DONE, OVERRUN;
   logic [1:0] VOICE_IDX;
   logic [6:0] VOICE_NOTE, VOICE_VEL;
   logic [2:0] ACTIVE_CNT;
   int checks = 0, failures = 0;
   int s_note [V], s_vel [V], s_gate [V], s_rs [V];
   nco_voice_scheduler #(.VOICES(V), .VIDX_W(2)) dut (
      .CLK(CLK), .RST(RST), .SAMPLE_TICK(SAMPLE_TICK), .EV_VALID(EV_VALID), .EV_READY(EV_READY),
      .EV_NOTE_ON(EV_NOTE_ON), .EV_NOTE(EV_NOTE), .EV_VEL(EV_VEL), .VOICE_STB(VOICE_STB),
      .VOICE_IDX(VOICE_IDX), .VOICE_NOTE(VOICE_NOTE), .VOICE_VEL(VOICE_VEL), .VOICE_GATE(VOICE_GATE),
      .VOICE_RESTART(VOICE_RESTART), .FRAME_DONE(FRAME_DONE), .OVERRUN(OVERRUN), .ACTIVE_CNT(ACTIVE_CNT));
   always #5 CLK = ~CLK;
   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic do_reset();
      RST = 1'b1;
      SAMPLE_TICK = 1'b0;
      EV_VALID = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
   endtask
   task automatic send(input bit on, input int n, input int v);
      int k = 0;
      EV_VALID = 1'b1;
      EV_NOTE_ON = on;
      EV_NOTE = 7'(n);
      EV_VEL = 7'(v);
      #1;
      while (!EV_READY && k < 20) begin
         @(negedge CLK);
         #1;
         k++;
      end
      check("ev_ready_wait", EV_READY, 1);
      @(negedge CLK);
      EV_VALID = 1'b0;
      repeat (2) @(negedge CLK);
   endtask
   task automatic capture(input int i);
      check("stb", VOICE_STB, 1);
      check("idx", VOICE_IDX, i);
      s_note[i] = VOICE_NOTE;
      s_vel[i] = VOICE_VEL;
      s_gate[i] = VOICE_GATE;
      s_rs[i] = VOICE_RESTART;
   endtask
   task automatic scan();
      SAMPLE_TICK = 1'b1;
      @(negedge CLK);
      SAMPLE_TICK = 1'b0;
      for (int i = 0; i < V; i++) begin
         capture(i);
         @(negedge CLK);
      end
      check("frame_done", FRAME_DONE, 1);
      check("stb_after", VOICE_STB, 0);
      @(negedge CLK);
      check("fd_pulse", FRAME_DONE, 0);
   endtask
   initial begin
      @(negedge CLK);
      do_reset();
      check("rst_ready", EV_READY, 1);
      check("rst_stb", VOICE_STB, 0);
      check("rst_note", VOICE_NOTE, 0);
      check("rst_fd", FRAME_DONE, 0);
      check("rst_ovr", OVERRUN, 0);
      check("rst_cnt", ACTIVE_CNT, 0);
      // 1: single note, restart only on first scan
      send(1, 60, 100);
      scan();
      check("t1_note0", s_note[0], 60);
      check("t1_vel0", s_vel[0], 100);
      check("t1_gate0", s_gate[0], 1);
      check("t1_rs0", s_rs[0], 1);
      for (int i = 1; i < V; i++) check("t1_gate_off", s_gate[i], 0);
      check("t1_cnt", ACTIVE_CNT, 1);
      scan();
      check("t1_rs0_second", s_rs[0], 0);
      check("t1_gate0_second", s_gate[0], 1);
      // 2: voice stealing rotates from slot 0
      do_reset();
      send(1, 60, 10);
      send(1, 62, 10);
      send(1, 64, 10);
      send(1, 67, 10);
      scan();
      check("t2_note3", s_note[3], 67);
      check("t2_cnt_full", ACTIVE_CNT, 4);
      send(1, 72, 20);
      scan();
      check("t2_steal0_note", s_note[0], 72);
      check("t2_steal0_vel", s_vel[0], 20);
      check("t2_steal0_rs", s_rs[0], 1);
      check("t2_slot1_rs", s_rs[1], 0);
      send(1, 74, 30);
      scan();
      check("t2_steal1_note", s_note[1], 74);
      check("t2_steal1_rs", s_rs[1], 1);
      check("t2_slot0_rs", s_rs[0], 0);
      check("t2_slot0_note", s_note[0], 72);
      check("t2_cnt_still", ACTIVE_CNT, 4);
      // 3: velocity-0 note-on releases, unmatched note-off is ignored
      do_reset();
      send(1, 60, 50);
      repeat (2) @(negedge CLK);
      check("t3_cnt1", ACTIVE_CNT, 1);
      send(1, 60, 0);
      scan();
      check("t3_gate0_off", s_gate[0], 0);
      check("t3_note_kept", s_note[0], 60);
      check("t3_cnt0", ACTIVE_CNT, 0);
      send(1, 62, 40);
      send(0, 61, 0);
      scan();
      check("t3_gate0_62", s_gate[0], 1);
      check("t3_note_62", s_note[0], 62);
      check("t3_cnt_62", ACTIVE_CNT, 1);
      // 4: tick beats a simultaneous event
      do_reset();
      EV_VALID = 1'b1;
      EV_NOTE_ON = 1'b1;
      EV_NOTE = 7'd50;
      EV_VEL = 7'd5;
      SAMPLE_TICK = 1'b1;
      #1;
      check("t4_ready_low", EV_READY, 0);
      @(negedge CLK);
      SAMPLE_TICK = 1'b0;
      for (int i = 0; i < V; i++) begin
         capture(i);
         @(negedge CLK);
      end
      check("t4_gate0_pre", s_gate[0], 0);
      check("t4_fd", FRAME_DONE, 1);
      check("t4_ready_done", EV_READY, 0);
      @(negedge CLK);
      check("t4_ready_t6", EV_READY, 1);
      @(negedge CLK);
      EV_VALID = 1'b0;
      repeat (2) @(negedge CLK);
      scan();
      check("t4_gate0_post", s_gate[0], 1);
      check("t4_note0_post", s_note[0], 50);
      // 5: tick during scan sets overrun and queues a back-to-back scan
      do_reset();
      SAMPLE_TICK = 1'b1;
      @(negedge CLK);
      SAMPLE_TICK = 1'b0;
      @(negedge CLK);
      SAMPLE_TICK = 1'b1;
      @(negedge CLK);
      SAMPLE_TICK = 1'b0;
      check("t5_ovr_set", OVERRUN, 1);
      repeat (2) @(negedge CLK);
      check("t5_fd", FRAME_DONE, 1);
      @(negedge CLK);
      check("t5_idle_stb", VOICE_STB, 0);
      check("t5_idle_ready", EV_READY, 0);
      @(negedge CLK);
      check("t5_rescan_stb", VOICE_STB, 1);
      check("t5_rescan_idx", VOICE_IDX, 0);
      repeat (4) @(negedge CLK);
      check("t5_fd2", FRAME_DONE, 1);
      repeat (3) @(negedge CLK);
      check("t5_ovr_sticky", OVERRUN, 1);
      do_reset();
      check("t5_ovr_clr", OVERRUN, 0);
      // 6: reset mid-scan abandons it
      send(1, 60, 100);
      SAMPLE_TICK = 1'b1;
      @(negedge CLK);
      SAMPLE_TICK = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("t6_stb", VOICE_STB, 0);
      check("t6_fd", FRAME_DONE, 0);
      check("t6_ready", EV_READY, 1);
      @(negedge CLK);
      check("t6_fd_later", FRAME_DONE, 0);
      check("t6_cnt", ACTIVE_CNT, 0);
      scan();
      check("t6_gate0", s_gate[0], 0);
      check("t6_note0", s_note[0], 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/nco_voice_scheduler.md
Name: nco_voice_scheduler

Overview:
Polyphony controller for the NCO datapath (phase register, phase adder, phase2sample). It takes MIDI-style note events, allocates them to VOICES slots, and on each sample tick from the 32 kHz prescaler it sequences the shared phase/sample datapath through every slot, one slot per clock. Downstream, a per-voice phase RAM and the mixer consume the strobe stream. This block holds no phase state; it owns only the voice table and the scan sequencing.

Parameters:
VOICES, 4, number of voice slots (2..16)
VIDX_W, 2, slot index width; must be at least clog2(VOICES)

Ports:
CLK  in  1  system clock (100 MHz)
RST  in  1  synchronous reset, active-high
SAMPLE_TICK  in  1  one-cycle pulse per output sample, from the prescaler CEO
EV_VALID  in  1  note event present
EV_READY  out  1  event accepted when EV_VALID and EV_READY are both high
EV_NOTE_ON  in  1  1 = note-on, 0 = note-off
EV_NOTE  in  7  MIDI note number
EV_VEL  in  7  velocity; a note-on with velocity 0 is treated as note-off
VOICE_STB  out  1  slot data valid this cycle (drives the datapath CE)
VOICE_IDX  out  VIDX_W  slot being processed
VOICE_NOTE  out  7  slot note, used as the step-ROM address
VOICE_VEL  out  7  slot velocity
VOICE_GATE  out  1  slot active
VOICE_RESTART  out  1  datapath must zero this slot's phase before accumulating
FRAME_DONE  out  1  one-cycle pulse after the last slot of a scan
OVERRUN  out  1  sticky flag: a tick arrived while a scan was in progress
ACTIVE_CNT  out  VIDX_W+1  number of gated slots

Behaviour:
- Reset:
  - All slots are cleared: gate=0, note=0, vel=0, restart=0.
  - Steal pointer = 0. Pending tick = 0. State = IDLE.
  - All outputs are 0, except EV_READY = 1 (combinational in IDLE).
- States: IDLE, EVAL, WRITE, SCAN, DONE.
- Priority in IDLE: a pending or current SAMPLE_TICK wins over an event.
  - If a tick is pending or SAMPLE_TICK is high, go to SCAN and hold EV_READY low that cycle.
  - Else, if EV_VALID, accept the event, capture it, and go to EVAL.
- EVAL (one cycle) computes the following from the captured event:
  - match = lowest slot with gate=1 and note=EV_NOTE.
  - free = lowest slot with gate=0.
- WRITE (one cycle), then return to IDLE:
  - Note-on with a match: retrigger that slot; vel updated, restart=1.
  - Note-on, no match, a free slot exists: fill the lowest free slot; gate=1, note, vel, restart=1.
  - Note-on, no match, no free slot: steal slot[steal pointer]; overwrite note/vel, restart=1, and increment the steal pointer modulo VOICES.
  - Note-off with a match: gate=0 on that slot. Note and vel are retained.
  - Note-off with no match: no change.
- Event throughput: at most one event per 3 cycles.
- SCAN timing: for a tick seen in IDLE at cycle t, VOICE_STB is high for cycles t+1 .. t+VOICES, with VOICE_IDX = 0 .. VOICES-1.
  - All VOICE_* outputs are registered and valid only while VOICE_STB is high. They are 0 otherwise.
  - A slot's restart flag is presented with its strobe and cleared in the same cycle.
- DONE: FRAME_DONE = 1 at cycle t+VOICES+1, then go to IDLE.
- Ticks outside IDLE:
  - A tick arriving in EVAL or WRITE sets pending. The scan starts on the next IDLE cycle, and pending clears when SCAN is entered.
  - A tick arriving in SCAN or DONE sets OVERRUN (sticky, cleared only by RST) and also sets pending.
  - Only one tick is ever queued.
- ACTIVE_CNT: registered population count of the gates, updated the cycle after WRITE.
- RST mid-scan: the scan is abandoned immediately and no FRAME_DONE is produced.

Test Plan:
1. Reset, then note-on 60 vel 100, then tick → one scan: slot0 STB with NOTE=60, GATE=1, RESTART=1; slots 1–3 GATE=0. FRAME_DONE at tick+5. A second tick gives slot0 RESTART=0.
2. Note-on 60/62/64/67 then note-on 72 (no free slot) → 72 steals slot0 with RESTART=1. A further note-on 74 steals slot1. ACTIVE_CNT stays 4.
3. Note-on 60, then note-on 60 vel 0 → slot0 GATE=0. ACTIVE_CNT goes 1 → 0. Note-off 61 changes nothing.
4. EV_VALID and SAMPLE_TICK high in the same IDLE cycle → EV_READY=0 and the scan runs first. The event is accepted at tick+6 and is visible from the next scan.
5. SAMPLE_TICK asserted during a scan (e.g. at tick+2) → OVERRUN=1. A second scan starts immediately after DONE. OVERRUN stays 1 until RST.
6. RST asserted at tick+3 → VOICE_STB=0, no FRAME_DONE, all gates cleared, EV_READY=1 on the next cycle.
